// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - CPU-side write/status bundle for the buffered UART transmitter
interface uart_tx_fifo_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ovf_clr;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_ovf;
    logic       uart_tx;

    modport master (
        output wr_en, wr_data, ovf_clr,
        input  tx_full, tx_empty, tx_busy, tx_done, tx_ovf, uart_tx
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr,
        output tx_full, tx_empty, tx_busy, tx_done, tx_ovf, uart_tx
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter, LSB first, back-to-back frames
module uart_tx_fifo #(
    parameter int BAUD_DIV = 434,
    parameter int FIFO_AW  = 2
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);

    localparam int                 DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_CNT  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [15:0]        BAUD_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               ovf;

    state_t             state;
    logic [15:0]        baud_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift;
    logic               line;
    logic               busy;
    logic               done;

    logic full, empty, baud_tc, pop, push;

    always_comb begin
        full    = (count == FULL_CNT);
        empty   = (count == '0);
        baud_tc = (baud_cnt == BAUD_LAST);
        // Head leaves the FIFO only when a new frame is launched.
        pop     = !empty && ((state == IDLE) || (state == STOP && baud_tc));
        // A pop in the same cycle frees a slot, so a write while full is still accepted.
        push    = bus.wr_en && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.wr_en && !push) begin
                ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            line     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    line <= 1'b1;
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        baud_cnt <= '0;
                        line     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        line     <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            line  <= 1'b1;
                            state <= STOP;
                        end else begin
                            line <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_tc) begin
                        done     <= 1'b1;
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            line  <= 1'b0;
                            state <= START;
                        end else begin
                            line  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    line  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_full  = full;
    assign bus.tx_empty = empty;
    assign bus.tx_busy  = busy;
    assign bus.tx_done  = done;
    assign bus.tx_ovf   = ovf;
    assign bus.uart_tx  = line;

endmodule
